// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multicycle RV32I control path
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALRADR, S_LUI
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEMDR  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps ALU operation class and funct fields to alu_control
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type: addi never subtracts
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b100:  alu_control = ALU_XOR;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM and immediate select for the multicycle RV32I core
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src
);

  state_t  state, state_next;
  alu_op_t alu_op;
  logic    taken;
  logic    pc_write_s, mem_write_s, ir_write_s, reg_write_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALRADR;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECR,
      S_EXECI:   state_next = S_ALUWB;
      S_JAL:     state_next = S_ALUWB;
      S_JALRADR: state_next = S_JAL;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg;
      3'b101:  taken = !neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write_s  = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALRADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_MEMDR;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write_s = taken;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_s = 1'b1;
      end
      S_LUI: begin
        result_src  = RES_IMM;
        reg_write_s = 1'b1;
      end
      default: ;
    endcase
  end

  // State is already FETCH while reset is held; only the write strobes need masking
  assign pc_write  = pc_write_s  & rst_n;
  assign mem_write = mem_write_s & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign reg_write = reg_write_s & rst_n;

  always_comb begin
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_LUI:    imm_src = IMM_U;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, neg;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  int passed = 0;
  int total  = 0;
  logic [16:0] exp_q[$];

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .neg(neg), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] mk(bit pcw, bit adr, bit mw, bit irw, bit rw,
                                     logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                     logic [2:0] alu, logic [2:0] imm);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm};
  endfunction

  function automatic logic [2:0] ref_imm(logic [6:0] o);
    case (o)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b0110111: return 3'd3;
      7'b1101111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(logic [2:0] f3, bit f7, bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 3'd1 : 3'd0;
      3'd7:    return 3'd2;
      3'd6:    return 3'd3;
      3'd4:    return 3'd4;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  // Expected per-cycle output trace of one whole instruction, from FETCH to its last cycle
  task automatic build(logic [6:0] o, logic [2:0] f3, bit f7, bit z, bit n);
    logic [2:0] im;
    bit tk;
    im = ref_imm(o);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, im));
    exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, im));
    case (o)
      7'b0000011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, im));
        exp_q.push_back(mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, im));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, im));
      end
      7'b0100011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, im));
        exp_q.push_back(mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, im));
      end
      7'b0110011, 7'b0010011: begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, (o == 7'b0110011) ? 2'd0 : 2'd1,
                           ref_alu(f3, f7, o == 7'b0110011), im));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, im));
      end
      7'b1100011: begin
        tk = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? n : (f3 == 3'd5) ? !n : 1'b0;
        exp_q.push_back(mk(tk, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, im));
      end
      7'b1101111, 7'b1100111: begin
        if (o == 7'b1100111) exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, im));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, im));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, im));
      end
      7'b0110111: exp_q.push_back(mk(0, 0, 0, 0, 1, 2'd3, 2'd0, 2'd0, 3'd0, im));
      default: ;
    endcase
  endtask

  task automatic check(string tag, logic [16:0] exp_v);
    logic [16:0] obs;
    obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_control, imm_src};
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %05h expected %05h", tag, obs, exp_v);
  endtask

  // Entered just after a rising edge with the FSM in FETCH; returns likewise
  task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, bit f7, bit z, bit n);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; neg = n;
    build(o, f3, f7, z, n);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", name, k + 1), exp_q[k]);
      @(posedge clk);
      #1;
    end
  endtask

  logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111};

  initial begin
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
    @(negedge clk);
    check("reset_hold", mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted while an add sits in EXECR
    @(negedge clk); check("pre_rst_fetch", mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    @(posedge clk); #1;
    @(negedge clk); check("pre_rst_decode", mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 3'd0));
    @(posedge clk); #1;
    @(negedge clk); check("pre_rst_execr", mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd0));
    #1 rst_n = 1'b0;
    #1 check("rst_async", mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    @(posedge clk); #1;
    @(negedge clk); check("rst_held", mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_instr("add",      7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("sub",      7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0);
    run_instr("addi_f7",  7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0);
    run_instr("lw",       7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0);
    run_instr("sw",       7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0);
    run_instr("beq_z1",   7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0);
    run_instr("beq_z0",   7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("bge_n0",   7'b1100011, 3'd5, 1'b0, 1'b0, 1'b0);
    run_instr("br_f3_2",  7'b1100011, 3'd2, 1'b0, 1'b1, 1'b1);
    run_instr("jal",      7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("jalr",     7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("lui",      7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr("illegal",  7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      run_instr($sformatf("rnd%0d", i), o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    check("final_fetch", mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, ref_imm(op)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
